// File: rtl/asrc_pkg.sv
// Shared types and default widths for the ASRC / upsampler FIR sequencing path.
package asrc_pkg;

  localparam int unsigned DefInW  = 16;
  localparam int unsigned DefFirW = 24;
  localparam int unsigned DefOutW = 28;

  localparam int unsigned NchMin = 2;
  localparam int unsigned NchMax = 4;

  // Channel counter must reach NchMax-1; receive index must also hold NchMax (overflow marker).
  localparam int unsigned ChW = $clog2(NchMax);
  localparam int unsigned RxW = $clog2(NchMax + 1);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap
  } seq_state_e;

endpackage

// File: rtl/fir_tdm_sequencer_if.sv
// Bundle of the I2S-side frame ports and the FIR sink/source streams of fir_tdm_sequencer.
interface fir_tdm_sequencer_if
  import asrc_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned IN_W  = DefInW,
  parameter int unsigned FIR_W = DefFirW,
  parameter int unsigned OUT_W = DefOutW
);

  logic [NCH*IN_W-1:0]  in_data_i;
  logic                 in_valid_i;
  logic [IN_W-1:0]      sink_data_o;
  logic                 sink_valid_o;
  logic                 sink_sop_o;
  logic                 sink_eop_o;
  logic [FIR_W-1:0]     source_data_i;
  logic                 source_valid_i;
  logic                 source_sop_i;
  logic                 source_eop_i;
  logic [NCH*OUT_W-1:0] out_data_o;
  logic                 out_valid_o;
  logic                 overrun_o;
  logic                 desync_o;

  // master: the sequencer itself; slave: the surrounding I2S receiver/FIR/transmitter.
  modport master (
    input  in_data_i, in_valid_i,
    output sink_data_o, sink_valid_o, sink_sop_o, sink_eop_o,
    input  source_data_i, source_valid_i, source_sop_i, source_eop_i,
    output out_data_o, out_valid_o, overrun_o, desync_o
  );

  modport slave (
    output in_data_i, in_valid_i,
    input  sink_data_o, sink_valid_o, sink_sop_o, sink_eop_o,
    output source_data_i, source_valid_i, source_sop_i, source_eop_i,
    input  out_data_o, out_valid_o, overrun_o, desync_o
  );

endinterface

// File: rtl/fir_tdm_demux.sv
// FIR source-stream demultiplexer: rebuilds a parallel, width-extended frame from a packet.
// Framing checks and the sticky desync flag exist only with FIR_SEQ_STATUS_EN defined.
module fir_tdm_demux
  import asrc_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned FIR_W = DefFirW,
  parameter int unsigned OUT_W = DefOutW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FIR_W-1:0]     src_data,
  input  logic                 src_valid,
  input  logic                 src_sop,
  input  logic                 src_eop,
  output logic [NCH*OUT_W-1:0] out_data,
  output logic                 out_valid,
  output logic                 desync
);

  localparam logic [RxW-1:0] NchR  = RxW'(NCH);
  localparam logic [RxW-1:0] LastR = RxW'(NCH - 1);

  logic [RxW-1:0]       rx_q, rx_d, idx;
  logic [NCH*OUT_W-1:0] staging_q, staging_d;
  logic [NCH*OUT_W-1:0] out_data_q;
  logic                 out_valid_q;
  logic [OUT_W-1:0]     beat_word;
  logic                 accept;
  logic                 publish;

  assign beat_word = OUT_W'(src_data) << (OUT_W - FIR_W);

  // Index of the current beat; saturates at NCH so an over-long packet stays detectable.
  always_comb begin
    idx = '0;
    if (!src_sop) begin
      idx = (rx_q >= NchR) ? NchR : rx_q + 1'b1;
    end
  end

`ifdef FIR_SEQ_STATUS_EN
  logic in_frame_q, in_frame_d;
  logic desync_q;
  logic err;

  always_comb begin
    accept     = 1'b0;
    err        = 1'b0;
    in_frame_d = in_frame_q;
    if (src_valid) begin
      if (src_sop) begin
        // A sop always restarts, but cutting a live frame short is still an error.
        accept = 1'b1;
        err    = in_frame_q;
      end else begin
        accept = in_frame_q && (idx < NchR);
        err    = !accept;
      end
      if (accept && src_eop && (idx != LastR)) begin
        accept = 1'b0;
        err    = 1'b1;
      end
      in_frame_d = accept && !src_eop;
    end
  end

  assign publish = src_valid && accept && src_eop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_frame_q <= 1'b0;
      desync_q   <= 1'b0;
    end else begin
      in_frame_q <= in_frame_d;
      desync_q   <= desync_q | err;
    end
  end

  assign desync = desync_q;
`else
  assign accept  = src_valid && (idx < NchR);
  assign publish = src_valid && src_eop;
  assign desync  = 1'b0;
`endif

  always_comb begin
    staging_d = staging_q;
    rx_d      = rx_q;
    if (src_valid) begin
      rx_d = idx;
      if (accept) begin
        staging_d[int'(idx)*OUT_W +: OUT_W] = beat_word;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q        <= '0;
      staging_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rx_q        <= rx_d;
      staging_q   <= staging_d;
      out_valid_q <= publish;
      if (publish) begin
        out_data_q <= staging_d;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/fir_tdm_sequencer.sv
// Shares one FIR between NCH channels: one-frame input buffer, serialising FSM, source demux.
// FIR_SEQ_STATUS_EN enables the sticky overrun/desync flags and source framing checks.
module fir_tdm_sequencer
  import asrc_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned IN_W  = DefInW,
  parameter int unsigned FIR_W = DefFirW,
  parameter int unsigned OUT_W = DefOutW
) (
  input logic               AMCLK_i,
  input logic               ARST_i,
  fir_tdm_sequencer_if.master bus
);

  localparam logic [ChW-1:0] LastCh = ChW'(NCH - 1);

  seq_state_e           state_q, state_d;
  logic [ChW-1:0]       ch_q, ch_d;
  logic [NCH*IN_W-1:0]  buf_q, shift_q;
  logic                 buf_full_q;
  logic                 load;
  logic                 send;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (buf_full_q) begin
          load    = 1'b1;
          ch_d    = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (ch_q == LastCh) begin
          state_d = StGap;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge AMCLK_i or posedge ARST_i) begin
    if (ARST_i) begin
      state_q <= StIdle;
      ch_q    <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      if (load) begin
        shift_q <= buf_q;
      end
    end
  end

  // A load frees the slot in the same cycle, so a coincident strobe is still captured.
  always_ff @(posedge AMCLK_i or posedge ARST_i) begin
    if (ARST_i) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else if (bus.in_valid_i && (!buf_full_q || load)) begin
      buf_q      <= bus.in_data_i;
      buf_full_q <= 1'b1;
    end else if (load) begin
      buf_full_q <= 1'b0;
    end
  end

`ifdef FIR_SEQ_STATUS_EN
  logic overrun_q;

  always_ff @(posedge AMCLK_i or posedge ARST_i) begin
    if (ARST_i) begin
      overrun_q <= 1'b0;
    end else if (bus.in_valid_i && buf_full_q && !load) begin
      overrun_q <= 1'b1;
    end
  end

  assign bus.overrun_o = overrun_q;
`else
  assign bus.overrun_o = 1'b0;
`endif

  // Sink outputs decode the state register directly, so reset silences them at once.
  assign send             = (state_q == StSend);
  assign bus.sink_valid_o = send;
  assign bus.sink_sop_o   = send && (ch_q == '0);
  assign bus.sink_eop_o   = send && (ch_q == LastCh);
  assign bus.sink_data_o  = send ? shift_q[int'(ch_q)*IN_W +: IN_W] : '0;

  fir_tdm_demux #(
    .NCH   (NCH),
    .FIR_W (FIR_W),
    .OUT_W (OUT_W)
  ) u_demux (
    .clk       (AMCLK_i),
    .rst       (ARST_i),
    .src_data  (bus.source_data_i),
    .src_valid (bus.source_valid_i),
    .src_sop   (bus.source_sop_i),
    .src_eop   (bus.source_eop_i),
    .out_data  (bus.out_data_o),
    .out_valid (bus.out_valid_o),
    .desync    (bus.desync_o)
  );

endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// Directed bench for fir_tdm_sequencer with NCH=2; expectations follow FIR_SEQ_STATUS_EN.
module tb_fir_tdm_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

`ifdef FIR_SEQ_STATUS_EN
  localparam logic StatusOn = 1'b1;
`else
  localparam logic StatusOn = 1'b0;
`endif

  always #5 clk = ~clk;

  fir_tdm_sequencer_if #(.NCH(2), .IN_W(16), .FIR_W(24), .OUT_W(28)) bus ();

  fir_tdm_sequencer #(
    .NCH   (2),
    .IN_W  (16),
    .FIR_W (24),
    .OUT_W (28)
  ) dut (
    .AMCLK_i (clk),
    .ARST_i  (rst),
    .bus     (bus.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_sink(input string tag, input logic v, input logic s, input logic e,
                            input logic [15:0] d);
    check({tag, "_valid"}, 64'(bus.sink_valid_o), 64'(v));
    check({tag, "_sop"},   64'(bus.sink_sop_o),   64'(s));
    check({tag, "_eop"},   64'(bus.sink_eop_o),   64'(e));
    check({tag, "_data"},  64'(bus.sink_data_o),  64'(d));
  endtask

  task automatic src_beat(input logic [23:0] d, input logic s, input logic e);
    bus.source_valid_i = 1'b1;
    bus.source_data_i  = d;
    bus.source_sop_i   = s;
    bus.source_eop_i   = e;
  endtask

  task automatic src_idle();
    bus.source_valid_i = 1'b0;
    bus.source_sop_i   = 1'b0;
    bus.source_eop_i   = 1'b0;
    bus.source_data_i  = '0;
  endtask

  initial begin
    bus.in_data_i  = '0;
    bus.in_valid_i = 1'b0;
    src_idle();

    // Reset state
    #2;
    check_sink("rst", 1'b0, 1'b0, 1'b0, 16'h0);
    check("rst_out_valid", 64'(bus.out_valid_o), 64'h0);
    check("rst_out_data",  64'(bus.out_data_o),  64'h0);
    check("rst_overrun",   64'(bus.overrun_o),   64'h0);
    check("rst_desync",    64'(bus.desync_o),    64'h0);
    tick();
    rst = 1'b0;
    tick();

    // Single frame: strobe at t
    bus.in_data_i  = {16'hABCD, 16'h1234};
    bus.in_valid_i = 1'b1;
    tick();                                   // t+1
    bus.in_valid_i = 1'b0;
    check("t1_sink_valid", 64'(bus.sink_valid_o), 64'h0);
    tick();                                   // t+2
    check_sink("beat0", 1'b1, 1'b1, 1'b0, 16'h1234);
    tick();                                   // t+3
    check_sink("beat1", 1'b1, 1'b0, 1'b1, 16'hABCD);
    tick();                                   // t+4 gap
    check_sink("gap", 1'b0, 1'b0, 1'b0, 16'h0);
    tick();

    // Loopback source packet: sop at s, eop at s+1
    src_beat(24'h123456, 1'b1, 1'b0);
    tick();                                   // s+1
    src_beat(24'hFEDCBA, 1'b0, 1'b1);
    check("lb_no_valid_early", 64'(bus.out_valid_o), 64'h0);
    tick();                                   // s+2
    src_idle();
    check("lb_out_valid", 64'(bus.out_valid_o), 64'h1);
    check("lb_out_data",  64'(bus.out_data_o),  64'h00FE_DCBA_0123_4560);
    tick();                                   // s+3
    check("lb_valid_pulse", 64'(bus.out_valid_o), 64'h0);
    check("lb_data_held",   64'(bus.out_data_o),  64'h00FE_DCBA_0123_4560);
    check("lb_desync",      64'(bus.desync_o),    64'h0);
    tick();

    // Three strobes on consecutive cycles: frame 2 queued, frame 3 dropped
    bus.in_data_i  = {16'h2222, 16'h1111};
    bus.in_valid_i = 1'b1;
    tick();                                   // t+1: load F1, capture F2
    bus.in_data_i  = {16'h4444, 16'h3333};
    check("ov_pre", 64'(bus.overrun_o), 64'h0);
    tick();                                   // t+2: F3 arrives with buffer full
    bus.in_data_i  = {16'h6666, 16'h5555};
    check_sink("f1b0", 1'b1, 1'b1, 1'b0, 16'h1111);
    tick();                                   // t+3
    bus.in_valid_i = 1'b0;
    check_sink("f1b1", 1'b1, 1'b0, 1'b1, 16'h2222);
    check("ov_set", 64'(bus.overrun_o), 64'(StatusOn));
    tick();                                   // t+4 gap
    check("f_gap", 64'(bus.sink_valid_o), 64'h0);
    tick();                                   // t+5 idle/load
    check("f_idle", 64'(bus.sink_valid_o), 64'h0);
    tick();                                   // t+6
    check_sink("f2b0", 1'b1, 1'b1, 1'b0, 16'h3333);
    tick();                                   // t+7
    check_sink("f2b1", 1'b1, 1'b0, 1'b1, 16'h4444);
    tick();
    tick();
    tick();                                   // F3 must never appear
    check("f3_dropped", 64'(bus.sink_valid_o), 64'h0);
    check("ov_sticky",  64'(bus.overrun_o),    64'(StatusOn));

    // Eop at rx=0
    src_beat(24'h111111, 1'b1, 1'b1);
    tick();
    src_idle();
    if (StatusOn) begin
      check("bad_no_valid", 64'(bus.out_valid_o), 64'h0);
      check("bad_data_kept", 64'(bus.out_data_o), 64'h00FE_DCBA_0123_4560);
    end else begin
      check("bad_valid_trust", 64'(bus.out_valid_o), 64'h1);
      check("bad_data_trust",  64'(bus.out_data_o),  64'h00FE_DCBA_0111_1110);
    end
    check("desync_set", 64'(bus.desync_o), 64'(StatusOn));
    tick();
    src_beat(24'h0AAAAA, 1'b1, 1'b0);
    tick();
    src_beat(24'h0BBBBB, 1'b0, 1'b1);
    tick();
    src_idle();
    check("resync_valid",  64'(bus.out_valid_o), 64'h1);
    check("resync_data",   64'(bus.out_data_o),  64'h000B_BBBB_00AA_AAA0);
    check("desync_sticky", 64'(bus.desync_o),    64'(StatusOn));
    tick();

    // Reset during the second sink beat
    bus.in_data_i  = {16'h8888, 16'h7777};
    bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    tick();
    check_sink("pre_rst_b0", 1'b1, 1'b1, 1'b0, 16'h7777);
    tick();
    check_sink("pre_rst_b1", 1'b1, 1'b0, 1'b1, 16'h8888);
    rst = 1'b1;
    #1;
    check_sink("mid_rst", 1'b0, 1'b0, 1'b0, 16'h0);
    check("mid_rst_out_valid", 64'(bus.out_valid_o), 64'h0);
    check("mid_rst_out_data",  64'(bus.out_data_o),  64'h0);
    check("mid_rst_overrun",   64'(bus.overrun_o),   64'h0);
    check("mid_rst_desync",    64'(bus.desync_o),    64'h0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", 64'(bus.sink_valid_o), 64'h0);
    bus.in_data_i  = {16'h9999, 16'h5A5A};
    bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    check("post_rst_t1", 64'(bus.sink_valid_o), 64'h0);
    tick();
    check_sink("post_rst_b0", 1'b1, 1'b1, 1'b0, 16'h5A5A);
    tick();
    check_sink("post_rst_b1", 1'b1, 1'b0, 1'b1, 16'h9999);
    tick();
    check_sink("post_rst_gap", 1'b0, 1'b0, 1'b0, 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fir_tdm_sequencer.md
# fir_tdm_sequencer

Time-division sequencer that shares one multi-channel audio FIR between NCH parallel sample channels in the I2S upsampler/ASRC path. Each parallel input frame from the I2S receiver is serialised into an Avalon-ST packet (sop on channel 0, eop on channel NCH-1) for the FIR. The FIR output stream is demultiplexed back into one parallel, width-extended frame with a single-cycle valid for the I2S transmitter. The block also buffers one frame, detects overruns and resynchronises on packet-framing errors.

## Interface
- NCH, 2: channels per frame (2..4); channel 0 = left
- IN_W, 16: input/FIR-sink sample width
- FIR_W, 24: FIR source data width
- OUT_W, 28: output sample width; FIR data is left-justified and zero-padded by OUT_W-FIR_W bits
- AMCLK_i  in  1  audio master clock; the only clock
- ARST_i  in  1  asynchronous, active-high reset
- in_data_i  in  NCH*IN_W  parallel frame; channel k at bits [k*IN_W +: IN_W]
- in_valid_i  in  1  one-cycle frame strobe
- sink_data_o  out  IN_W  FIR sink data
- sink_valid_o / sink_sop_o / sink_eop_o  out  1 each  FIR sink framing
- source_data_i  in  FIR_W  FIR source data
- source_valid_i / source_sop_i / source_eop_i  in  1 each  FIR source framing
- out_data_o  out  NCH*OUT_W  parallel filtered frame, same channel packing as the input
- out_valid_o  out  1  one-cycle strobe; out_data_o is valid and held until the next strobe
- overrun_o  out  1  a frame arrived while the buffer was full
- desync_o  out  1  a source framing error was seen

## Operation
- All outputs are 0 during reset.
- Input buffer holds one frame plus a full flag. in_valid_i sets the flag and captures the frame.
- If in_valid_i is high while the buffer is full, the new frame is dropped, the buffer keeps the old frame and an overrun is recorded.
- The flag clears when the sequencer loads the buffer. If a load and an in_valid_i occur in the same cycle, the new frame is captured and the flag stays set.
- Sequencer FSM:
  - IDLE: if the buffer is full, load it into the shift register, set ch=0 and go to SEND.
  - SEND: drive sink_valid_o=1 and sink_data_o = channel ch. sink_sop_o = (ch==0). sink_eop_o = (ch==NCH-1).
  - In SEND, ch increments each cycle. After ch==NCH-1 the FSM goes to GAP.
  - GAP: one cycle with sink_valid/sop/eop=0, then IDLE.
- Demux: a receive index rx is updated on each source_valid_i beat.
  - On a sop beat, rx restarts at 0; otherwise it increments.
  - Each beat writes channel rx as {source_data_i, (OUT_W-FIR_W) zeros} into a staging register.
- A complete frame is a sop beat, then beats in order, with eop exactly at rx==NCH-1. On a complete frame, staging copies to out_data_o and out_valid_o pulses.
- Framing errors:
  - eop at rx≠NCH-1
  - a beat without sop at rx==NCH-1 or later
  - sop in the middle of a frame
- On a framing error: discard the partial frame, record desync, then ignore beats until the next sop. A mid-frame sop starts the new frame immediately.
- No backpressure: the FIR accepts every sink beat.

## Timing
- in_valid_i high at cycle t with the FSM in IDLE and the buffer empty:
  - buffer full at t+1
  - sink beats (ch 0..NCH-1) on cycles t+2 .. t+NCH+1
  - GAP at t+NCH+2
  - next load possible at t+NCH+3
- Sustained input period must be at least NCH+2 cycles. One extra frame can be absorbed by the buffer.
- Eop source beat at cycle s gives out_valid_o=1 and the new out_data_o at s+1. out_valid_o is low at s+2.
- Reset asserted mid-packet: sink_valid_o drops asynchronously. No partial packet resumes. The buffer, staging and rx all clear.

## Configuration
- FIR_SEQ_STATUS_EN defined:
  - overrun_o and desync_o are sticky and cleared only by ARST_i.
  - Framing checks and resynchronisation are active as described.
- FIR_SEQ_STATUS_EN undefined:
  - overrun_o and desync_o are tied 0 and the error logic is removed.
  - The demux trusts framing: sop resets rx, and eop publishes the frame regardless of rx.
  - Overrun drop behaviour is unchanged.

## Structure
- Shared package `asrc_pkg`:
  - FSM state typedef (IDLE, SEND, GAP)
  - default widths IN_W=16, FIR_W=24, OUT_W=28
  - NCH bounds
- One sub-module, `fir_tdm_demux`: source-side rx counter, staging, framing checks and output registers.
- The sequencer FSM and input buffer stay in the top level.

## Test plan
- NCH=2, in_data L=0x1234 R=0xABCD, strobe at t:
  - sink beats 0x1234 (sop) at t+2 and 0xABCD (eop) at t+3
  - sink_valid low at t+4
- Loopback source beats 0x123456 (sop) and 0xFEDCBA (eop) at s, s+1 → out_valid at s+2 with out_data = {0xFEDCBA0, 0x1234560}.
- Three strobes 1 cycle apart:
  - frames 1 and 2 are sent back to back, with GAP between them
  - frame 3 is dropped and overrun_o rises and stays 1 (macro on)
- Source sends eop at rx=0:
  - no out_valid and desync_o=1
  - the next proper sop/eop pair publishes the frame normally
- Assert ARST_i during the second sink beat:
  - all outputs are 0 immediately
  - after release, a new strobe produces a clean packet starting with sop
- Build without FIR_SEQ_STATUS_EN and repeat the desync stimulus → overrun_o=desync_o=0 throughout.
